// File: rtl/cpu_din_mux_n_if.sv
// Bus bundle between the device read buses, the Z80 DI port and cpu_din_mux_n.
// coll_count / first_coll_idx exist only when CPU_DIN_CONTENTION_LOG_EN is defined.
interface cpu_din_mux_n_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NSRC   = 16
);
  localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC*DATA_W-1:0] src_data;
  logic [NSRC-1:0]        src_sel;
  logic                   reset_cs;
  logic                   z80Read;
  logic [DATA_W-1:0]      s100DataIn;
  logic                   err_clr;
  logic [DATA_W-1:0]      outData;
  logic                   data_valid;
  logic                   src_hit;
  logic [IDX_W-1:0]       active_src;
  logic                   multi_sel;
`ifdef CPU_DIN_CONTENTION_LOG_EN
  logic [7:0]             coll_count;
  logic [IDX_W-1:0]       first_coll_idx;

  modport master (
    output src_data, src_sel, reset_cs, z80Read, s100DataIn, err_clr,
    input  outData, data_valid, src_hit, active_src, multi_sel, coll_count, first_coll_idx
  );
  modport slave (
    input  src_data, src_sel, reset_cs, z80Read, s100DataIn, err_clr,
    output outData, data_valid, src_hit, active_src, multi_sel, coll_count, first_coll_idx
  );
`else
  modport master (
    output src_data, src_sel, reset_cs, z80Read, s100DataIn, err_clr,
    input  outData, data_valid, src_hit, active_src, multi_sel
  );
  modport slave (
    input  src_data, src_sel, reset_cs, z80Read, s100DataIn, err_clr,
    output outData, data_valid, src_hit, active_src, multi_sel
  );
`endif
endinterface

// File: rtl/cpu_din_mux_n.sv
// Fixed-priority CPU data-in selector: synchronised read strobe, settle window, per-read freeze.
// Define CPU_DIN_CONTENTION_LOG_EN to add the collision counter and first-collision index.
module cpu_din_mux_n #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       NSRC       = 16,
  parameter int unsigned       SETTLE_CYC = 2,
  parameter logic [DATA_W-1:0] RESET_FILL = '0
) (
  input logic            pll0_250MHz,
  input logic            n_reset,
  cpu_din_mux_n_if.slave bus
);
  localparam int unsigned IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [DATA_W-1:0] outQ, outNext;
  logic              dvQ, dvNext;
  logic              hitQ, hitNext;
  logic [IDX_W-1:0]  idxQ, idxNext;
  logic              rdMeta, rdS, rdSD;
  logic              multiQ;

  logic [DATA_W-1:0] srcWord_c [NSRC];
  logic [NSRC-1:0]   hiSel_c, sel2_c;
  logic [IDX_W-1:0]  hiIdx_c;
  logic              rdRise_c, coll_c, loadCand_c;
  logic              candValid_c, candHit_c;
  logic [DATA_W-1:0] candData_c;
  logic [IDX_W-1:0]  candIdx_c;

  // Index of the lowest set bit (highest priority), 0 when none is set.
  function automatic logic [IDX_W-1:0] lowestIdx(input logic [NSRC-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  for (genvar g = 0; g < NSRC; g++) begin : g_split
    assign srcWord_c[g] = bus.src_data[g*DATA_W +: DATA_W];
  end

  // Clearing the lowest set bit leaves a non-zero vector exactly when two or more selects collide.
  assign hiSel_c  = bus.src_sel & ~NSRC'(1);
  assign hiIdx_c  = lowestIdx(hiSel_c);
  assign sel2_c   = bus.src_sel & (bus.src_sel - NSRC'(1));
  assign coll_c   = |sel2_c;
  assign rdRise_c = rdS & ~rdSD;

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      rdMeta <= 1'b0;
      rdS    <= 1'b0;
      rdSD   <= 1'b0;
    end else begin
      rdMeta <= bus.z80Read;
      rdS    <= rdMeta;
      rdSD   <= rdS;
    end
  end

  // Boot source 0 beats the NOP fill; the S-100 bus only drives during a read.
  always_comb begin
    candValid_c = 1'b1;
    candHit_c   = |bus.src_sel;
    candIdx_c   = '0;
    candData_c  = RESET_FILL;
    if (bus.src_sel[0]) begin
      candData_c = srcWord_c[0];
    end else if (bus.reset_cs) begin
      candData_c = RESET_FILL;
    end else if (|hiSel_c) begin
      candIdx_c  = hiIdx_c;
      candData_c = srcWord_c[hiIdx_c];
    end else if (rdS) begin
      candData_c = bus.s100DataIn;
    end else begin
      candValid_c = 1'b0;
    end
  end

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      cnt   <= '0;
      outQ  <= RESET_FILL;
      dvQ   <= 1'b0;
      hitQ  <= 1'b0;
      idxQ  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      outQ  <= outNext;
      dvQ   <= dvNext;
      hitQ  <= hitNext;
      idxQ  <= idxNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    dvNext     = dvQ;
    outNext    = outQ;
    hitNext    = hitQ;
    idxNext    = idxQ;
    loadCand_c = 1'b0;
    case (state)
      IDLE: begin
        dvNext     = 1'b0;
        loadCand_c = candValid_c;
        if (rdRise_c) begin
          if (SETTLE_CYC == 0) begin
            stateNext = HOLD;
            dvNext    = 1'b1;
          end else begin
            stateNext = SETTLE;
            cntNext   = CNT_W'(SETTLE_CYC);
          end
        end
      end
      SETTLE: begin
        loadCand_c = candValid_c;
        if (!rdS) begin
          stateNext = IDLE;
          dvNext    = 1'b0;
        end else if (cnt <= CNT_W'(1)) begin
          stateNext = HOLD;
          dvNext    = 1'b1;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (!rdS) begin
          stateNext = IDLE;
          dvNext    = 1'b0;
        end
      end
      default: begin
        stateNext = IDLE;
        dvNext    = 1'b0;
      end
    endcase
    if (loadCand_c) begin
      outNext = candData_c;
      hitNext = candHit_c;
      idxNext = candIdx_c;
    end
  end

  // Sticky collision flag; a collision in the clearing cycle keeps it set.
  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      multiQ <= 1'b0;
    end else if (coll_c) begin
      multiQ <= 1'b1;
    end else if (bus.err_clr) begin
      multiQ <= 1'b0;
    end
  end

  assign bus.outData    = outQ;
  assign bus.data_valid = dvQ;
  assign bus.src_hit    = hitQ;
  assign bus.active_src = idxQ;
  assign bus.multi_sel  = multiQ;

`ifdef CPU_DIN_CONTENTION_LOG_EN
  logic [7:0]       collCount, collBase_c;
  logic [IDX_W-1:0] firstIdx;
  logic             firstSeen, seenBase_c;

  // err_clr acts first, then the current cycle's collision is counted on top.
  assign collBase_c = bus.err_clr ? 8'h00 : collCount;
  assign seenBase_c = bus.err_clr ? 1'b0 : firstSeen;

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      collCount <= 8'h00;
      firstSeen <= 1'b0;
      firstIdx  <= '0;
    end else begin
      collCount <= (coll_c && (collBase_c != 8'hFF)) ? collBase_c + 8'h01 : collBase_c;
      firstSeen <= seenBase_c | coll_c;
      if (coll_c && !seenBase_c) begin
        firstIdx <= lowestIdx(sel2_c);
      end else if (bus.err_clr) begin
        firstIdx <= '0;
      end
    end
  end

  assign bus.coll_count     = collCount;
  assign bus.first_coll_idx = firstIdx;
`else
  // Without the log, multi_sel alone reports contention.
`endif

endmodule

// File: tb/tb_cpu_din_mux_n.sv
// Scoreboard bench for cpu_din_mux_n: directed cases plus randomized reads against a priority model.
module tb_cpu_din_mux_n;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned NSRC       = 16;
  localparam int unsigned SETTLE_CYC = 2;
  localparam logic [7:0]  FILL       = 8'h00;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       hit;
    logic [3:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset;
  int   errors = 0;
  int   checks = 0;

  exp_t expQ[$];
  exp_t cur;
  logic dvPrev;
  logic expMulti;
  logic [7:0]   expOut;
  logic         expHit;
  logic [3:0]   expIdx;
  logic [15:0]  curSel;
  logic [127:0] curD;
  logic [7:0]   curS100;
`ifdef CPU_DIN_CONTENTION_LOG_EN
  int         expCount;
  logic [3:0] expFirst;
  logic       expSeen;
`endif

  always #2 clk = ~clk;

  cpu_din_mux_n_if #(.DATA_W(DATA_W), .NSRC(NSRC)) bus ();

  cpu_din_mux_n #(
    .DATA_W(DATA_W), .NSRC(NSRC), .SETTLE_CYC(SETTLE_CYC), .RESET_FILL(FILL)
  ) dut (
    .pll0_250MHz(clk),
    .n_reset(n_reset),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: first asserted select in index order, with reset_cs outranking every index but 0.
  function automatic exp_t pick(input logic [15:0] sel, input logic [127:0] d, input logic rcs,
                                input logic rd, input logic [7:0] s100);
    exp_t e;
    int   first;
    first   = -1;
    for (int i = 0; i < 16; i++) if (sel[i] && first < 0) first = i;
    e.valid = 1'b1;
    e.hit   = (sel != 16'h0000);
    e.idx   = 4'h0;
    e.data  = FILL;
    if (first == 0)      e.data = d[7:0];
    else if (rcs)        e.data = FILL;
    else if (first > 0) begin
      e.data = d[first*8 +: 8];
      e.idx  = 4'(first);
    end
    else if (rd)         e.data = s100;
    else                 e.valid = 1'b0;
    return e;
  endfunction

  function automatic logic [3:0] secondIdx(input logic [15:0] sel);
    int seen;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (sel[i]) begin
        seen++;
        if (seen == 2) return 4'(i);
      end
    end
    return 4'h0;
  endfunction

  function automatic int bumpCount(input int c, input logic coll);
    if (!coll) return c;
    return (c >= 255) ? 255 : c + 1;
  endfunction

  function automatic logic [15:0] randSel();
    logic [15:0] s;
    int a, b;
    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    case ($urandom_range(0, 5))
      0:       s = 16'h0000;
      1, 2:    s = 16'(1) << a;
      3:       s = (16'(1) << a) | (16'(1) << b);
      4:       s = 16'($urandom);
      default: s = 16'(1) << $urandom_range(1, 15);
    endcase
    return s;
  endfunction

  function automatic logic [127:0] randData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sticky flag / collision log reference, sampled from the bench's own drive.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      expMulti <= 1'b0;
`ifdef CPU_DIN_CONTENTION_LOG_EN
      expCount <= 0;
      expFirst <= 4'h0;
      expSeen  <= 1'b0;
`endif
    end else begin
      if ($countones(bus.src_sel) >= 2) expMulti <= 1'b1;
      else if (bus.err_clr)             expMulti <= 1'b0;
`ifdef CPU_DIN_CONTENTION_LOG_EN
      expCount <= bumpCount(bus.err_clr ? 0 : expCount, $countones(bus.src_sel) >= 2);
      if (($countones(bus.src_sel) >= 2) && (bus.err_clr || !expSeen)) begin
        expSeen  <= 1'b1;
        expFirst <= secondIdx(bus.src_sel);
      end else if (bus.err_clr) begin
        expSeen  <= 1'b0;
        expFirst <= 4'h0;
      end
`endif
    end
  end

  // Monitor: pop an expectation at each data_valid rise, then insist the byte stays frozen.
  always @(negedge clk) begin
    if (!n_reset) begin
      dvPrev = 1'b0;
    end else begin
      if (bus.data_valid && !dvPrev) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: data_valid rose with no read pending (got 1, expected 0)");
        end else begin
          cur = expQ.pop_front();
          check("frozen_data", 32'(bus.outData), 32'(cur.data));
          check("frozen_hit", 32'(bus.src_hit), 32'(cur.hit));
          check("frozen_idx", 32'(bus.active_src), 32'(cur.idx));
        end
      end else if (bus.data_valid) begin
        check("hold_stable", 32'(bus.outData), 32'(cur.data));
      end
      dvPrev = bus.data_valid;
      check("multi_sel", 32'(bus.multi_sel), 32'(expMulti));
`ifdef CPU_DIN_CONTENTION_LOG_EN
      check("coll_count", 32'(bus.coll_count), 32'(expCount));
      check("first_coll_idx", 32'(bus.first_coll_idx), 32'(expFirst));
`endif
    end
  end

  task automatic applyIn(input logic [15:0] sel, input logic [127:0] d, input logic rcs,
                         input logic [7:0] s100);
    bus.src_sel    = sel;
    bus.src_data   = d;
    bus.reset_cs   = rcs;
    bus.s100DataIn = s100;
    curSel  = sel;
    curD    = d;
    curS100 = s100;
  endtask

  task automatic track(input logic [15:0] sel, input logic [127:0] d, input logic rcs,
                       input logic [7:0] s100);
    exp_t e;
    e = pick(sel, d, rcs, 1'b0, s100);
    if (e.valid) begin
      expOut = e.data;
      expHit = e.hit;
      expIdx = e.idx;
    end
  endtask

  // One idle cycle: called on a negedge, returns on the next one.
  task automatic idleStep(input logic [15:0] sel, input logic [127:0] d, input logic rcs,
                          input logic [7:0] s100);
    applyIn(sel, d, rcs, s100);
    @(negedge clk);
    track(sel, d, rcs, s100);
    check("idle_data", 32'(bus.outData), 32'(expOut));
    check("idle_hit", 32'(bus.src_hit), 32'(expHit));
    check("idle_idx", 32'(bus.active_src), 32'(expIdx));
  endtask

  task automatic pulseErr(input logic [15:0] sel);
    applyIn(sel, curD, 1'b0, curS100);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    track(sel, curD, 1'b0, curS100);
  endtask

  task automatic readTxn(input logic [15:0] sel, input logic [127:0] d, input logic rcs,
                         input logic [7:0] s100, input int holdCyc,
                         input logic [15:0] hSel, input logic [127:0] hD, input logic hRcs);
    exp_t e;
    int   n;
    applyIn(sel, d, rcs, s100);
    e = pick(sel, d, rcs, 1'b1, s100);
    expQ.push_back(e);
    bus.z80Read = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.data_valid && n < 20);
    check("rd_latency", 32'(n), 32'(3 + SETTLE_CYC));
    applyIn(hSel, hD, hRcs, s100);
    repeat (holdCyc) @(negedge clk);
    bus.z80Read = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.data_valid && n < 20);
    check("rd_release", 32'(n), 32'd3);
    check("exit_frozen", 32'(bus.outData), 32'(e.data));
    expOut = e.data;
    expHit = e.hit;
    expIdx = e.idx;
    @(negedge clk);
    track(hSel, hD, hRcs, s100);
    check("post_track", 32'(bus.outData), 32'(expOut));
    check("post_hit", 32'(bus.src_hit), 32'(expHit));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] d, hd;
    int n;
    n_reset     = 1'b0;
    bus.z80Read = 1'b0;
    bus.err_clr = 1'b0;
    applyIn(16'h0000, '0, 1'b0, 8'h00);
    expOut = FILL;
    expHit = 1'b0;
    expIdx = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(bus.outData), 32'(FILL));
    check("rst_dv", 32'(bus.data_valid), 32'd0);
    check("rst_hit", 32'(bus.src_hit), 32'd0);
    check("rst_idx", 32'(bus.active_src), 32'd0);
    check("rst_multi", 32'(bus.multi_sel), 32'd0);
    n_reset = 1'b1;

    // Priority: index 4, then NOP fill, then source 0 over reset_cs.
    d = '0; d[39:32] = 8'h4D;
    idleStep(16'h0010, d, 1'b0, 8'h00);
    idleStep(16'h0000, d, 1'b1, 8'h00);
    d = '0; d[7:0] = 8'hC3;
    idleStep(16'h0001, d, 1'b1, 8'h00);

    // Hold: source 5 frozen at 5A while its bus changes to 11.
    d = randData(); d[47:40] = 8'h5A;
    hd = d; hd[47:40] = 8'h11;
    readTxn(16'h0020, d, 1'b0, 8'h00, 4, 16'h0020, hd, 1'b0);
    check("hold_then_track", 32'(bus.outData), 32'h11);

    // Abort: one-cycle strobe dies inside the settle window.
    d = randData();
    applyIn(16'h0200, d, 1'b0, 8'h00);
    bus.z80Read = 1'b1;
    @(negedge clk);
    bus.z80Read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_dv", 32'(bus.data_valid), 32'd0);
    end
    track(16'h0200, d, 1'b0, 8'h00);
    idleStep(16'h0040, randData(), 1'b0, 8'h00);

    // Fallback to the S-100 bus.
    readTxn(16'h0000, randData(), 1'b0, 8'hA7, 2, 16'h0000, randData(), 1'b0);
    check("fallback_out", 32'(bus.outData), 32'hA7);
    check("fallback_hit", 32'(bus.src_hit), 32'd0);

    // Collision between sources 3 and 7 for three cycles.
    pulseErr(16'h0000);
    d = randData(); d[31:24] = 8'h3C; d[63:56] = 8'h7E;
    repeat (3) idleStep(16'h0088, d, 1'b0, 8'h00);
    check("coll_multi", 32'(bus.multi_sel), 32'd1);
    check("coll_out", 32'(bus.outData), 32'h3C);
    check("coll_idx", 32'(bus.active_src), 32'd3);
`ifdef CPU_DIN_CONTENTION_LOG_EN
    check("coll_cnt3", 32'(bus.coll_count), 32'd3);
    check("coll_first7", 32'(bus.first_coll_idx), 32'd7);
`endif
    pulseErr(16'h0000);
    check("clr_multi", 32'(bus.multi_sel), 32'd0);
`ifdef CPU_DIN_CONTENTION_LOG_EN
    check("clr_cnt", 32'(bus.coll_count), 32'd0);
`endif

    // Randomized reads with scrambled inputs during HOLD, mixed with idle cycles.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) pulseErr(randSel());
      readTxn(randSel(), randData(), ($urandom_range(0, 3) == 0), 8'($urandom),
              $urandom_range(0, 5), randSel(), randData(), ($urandom_range(0, 3) == 0));
      for (int k = 0; k < 3; k++)
        idleStep(randSel(), randData(), ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    // Asynchronous reset in the middle of HOLD with multi_sel set.
    idleStep(16'h0006, randData(), 1'b0, 8'h00);
    d = randData(); d[23:16] = 8'h9C;
    applyIn(16'h0004, d, 1'b0, 8'h00);
    expQ.push_back(pick(16'h0004, d, 1'b0, 1'b1, 8'h00));
    bus.z80Read = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.data_valid && n < 20);
    check("arst_latency", 32'(n), 32'(3 + SETTLE_CYC));
    check("arst_pre_multi", 32'(bus.multi_sel), 32'd1);
    #1 n_reset = 1'b0;
    #1;
    check("arst_out", 32'(bus.outData), 32'(FILL));
    check("arst_dv", 32'(bus.data_valid), 32'd0);
    check("arst_multi", 32'(bus.multi_sel), 32'd0);
    check("arst_hit", 32'(bus.src_hit), 32'd0);
    expQ.delete();
    bus.z80Read = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
